// File: rtl/ascii_num_parser.sv
// Purpose : parses decimal ASCII numbers from a byte stream into a show-ahead token FIFO.
// Latency : a token is visible on num_valid one cycle after its terminator byte is strobed.
// Backpres: input has none (tokens are dropped and overflow set when the FIFO is full);
//           output uses num_valid/num_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   input_valid, input_data  byte strobe and received byte
//   num_valid, num_ready     head-token handshake
//   num_value                head token value (0 when num_valid=0)
//   num_eol                  head token ended by newline
//   num_blank                head token is an empty line
//   num_wrapped              head token value was reduced modulo 2^WIDTH
//   overflow                 sticky: a token was dropped because the FIFO was full
module ascii_num_parser #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             input_valid,
    input  logic [7:0]       input_data,
    output logic             num_valid,
    input  logic             num_ready,
    output logic [WIDTH-1:0] num_value,
    output logic             num_eol,
    output logic             num_blank,
    output logic             num_wrapped,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] value;
        logic             eol;
        logic             blank;
        logic             wrapped;
    } tok_t;

    // Parser state
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             pend_q, pend_d;
    logic             wrap_q, wrap_d;

    // FIFO state
    tok_t             mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             push;
    tok_t             push_tok;
    logic             pop;
    logic             accept;
    logic             is_digit;
    logic [WIDTH+3:0] prod;

    assign is_digit = (input_data >= 8'h30) && (input_data <= 8'h39);

    // Exact acc*10+digit; four extra bits are enough for the worst case, and any
    // set bit above WIDTH means the value no longer fits.
    assign prod = {4'b0000, acc_q} * (WIDTH+4)'(10) + (WIDTH+4)'(input_data[3:0]);

    always_comb begin
        acc_d    = acc_q;
        pend_d   = pend_q;
        wrap_d   = wrap_q;
        push     = 1'b0;
        push_tok = '0;
        if (input_valid) begin
            if (is_digit) begin
                acc_d  = prod[WIDTH-1:0];
                pend_d = 1'b1;
                if (prod[WIDTH+3:WIDTH] != 4'd0) begin
                    wrap_d = 1'b1;
                end
            end else if (input_data == 8'h0A) begin
                push         = 1'b1;
                push_tok.eol = 1'b1;
                if (pend_q) begin
                    push_tok.value   = acc_q;
                    push_tok.wrapped = wrap_q;
                end else begin
                    push_tok.blank = 1'b1;
                end
            end else if (input_data != 8'h0D && pend_q) begin
                // Any other non-CR byte ends a pending number
                push             = 1'b1;
                push_tok.value   = acc_q;
                push_tok.wrapped = wrap_q;
            end
        end
        // A push clears the parser whether or not the FIFO takes the token
        if (push) begin
            acc_d  = '0;
            pend_d = 1'b0;
            wrap_d = 1'b0;
        end
    end

    assign num_valid = (count_q != '0);
    assign pop       = num_valid && num_ready;
    // A full FIFO can still take a token when the head leaves in the same cycle
    assign accept    = push && ((count_q != FULL_CNT) || pop);

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (accept) begin
            wr_d = wr_q + 1'b1;
        end
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!accept && pop) begin
            count_d = count_q - 1'b1;
        end
        if (push && !accept) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            pend_q  <= 1'b0;
            wrap_q  <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            pend_q  <= pend_d;
            wrap_q  <= wrap_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem_q[wr_q] <= push_tok;
        end
    end

    tok_t head;
    assign head        = mem_q[rd_q];
    assign num_value   = num_valid ? head.value : '0;
    assign num_eol     = num_valid && head.eol;
    assign num_blank   = num_valid && head.blank;
    assign num_wrapped = num_valid && head.wrapped;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ascii_num_parser.sv
// Purpose : self-checking bench for ascii_num_parser (WIDTH=32, DEPTH=4).
// Latency : reference model steps on every rising edge, outputs compared on every falling edge.
// Backpres: stimulus drives num_ready directly, including long stalls to force overflow.
module tb_ascii_num_parser;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam longint unsigned MASK = (64'd1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             input_valid = 1'b0;
    logic [7:0]       input_data = 8'h00;
    logic             num_ready = 1'b0;
    logic             num_valid;
    logic [WIDTH-1:0] num_value;
    logic             num_eol;
    logic             num_blank;
    logic             num_wrapped;
    logic             overflow;

    always #5 clk = ~clk;

    ascii_num_parser #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .input_valid (input_valid),
        .input_data  (input_data),
        .num_valid   (num_valid),
        .num_ready   (num_ready),
        .num_value   (num_value),
        .num_eol     (num_eol),
        .num_blank   (num_blank),
        .num_wrapped (num_wrapped),
        .overflow    (overflow)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint unsigned v;
        bit eol;
        bit blank;
        bit wr;
    } tok_t;

    // Reference model: exact arithmetic on a 64-bit accumulator and a queue for the FIFO
    tok_t            mq[$];
    tok_t            got[$];
    longint unsigned m_acc;
    bit              m_pend, m_wrap, m_ovf;
    bit              live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_acc  = 0;
            m_pend = 1'b0;
            m_wrap = 1'b0;
            m_ovf  = 1'b0;
            mq.delete();
            live   = 1'b1;
        end else begin
            bit              do_push;
            bit              do_pop;
            tok_t            t;
            int              sz;
            longint unsigned e;
            do_push = 1'b0;
            t = '{0, 1'b0, 1'b0, 1'b0};
            if (input_valid) begin
                if (input_data >= 8'h30 && input_data <= 8'h39) begin
                    e = m_acc * 10 + longint'(input_data - 8'h30);
                    if (e > MASK) m_wrap = 1'b1;
                    m_acc  = e & MASK;
                    m_pend = 1'b1;
                end else if (input_data == 8'h0A) begin
                    do_push = 1'b1;
                    t = m_pend ? '{m_acc, 1'b1, 1'b0, m_wrap} : '{0, 1'b1, 1'b1, 1'b0};
                end else if (input_data != 8'h0D && m_pend) begin
                    do_push = 1'b1;
                    t = '{m_acc, 1'b0, 1'b0, m_wrap};
                end
            end
            if (do_push) begin
                m_acc  = 0;
                m_pend = 1'b0;
                m_wrap = 1'b0;
            end
            sz = mq.size();
            do_pop = (sz > 0) && num_ready;
            if (do_pop) begin
                // Log what the DUT actually handed over, for the literal checks
                got.push_back('{longint'(num_value), num_eol, num_blank, num_wrapped});
                void'(mq.pop_front());
            end
            if (do_push) begin
                if (sz < DEPTH || do_pop) mq.push_back(t);
                else m_ovf = 1'b1;
            end
        end
    end

    // Cycle-by-cycle compare of every output against the model
    always @(negedge clk) begin
        if (live) begin
            logic [WIDTH+4:0] act;
            logic [WIDTH+4:0] exp;
            act = {num_valid, num_value, num_eol, num_blank, num_wrapped, overflow};
            if (mq.size() > 0)
                exp = {1'b1, mq[0].v[WIDTH-1:0], mq[0].eol, mq[0].blank, mq[0].wr, m_ovf};
            else
                exp = {1'b0, {WIDTH{1'b0}}, 3'b000, m_ovf};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got vld=%0b val=%0d eol=%0b blank=%0b wr=%0b ovf=%0b want vld=%0b val=%0d eol=%0b blank=%0b wr=%0b ovf=%0b",
                         $time, act[WIDTH+4], act[WIDTH+3:4], act[3], act[2], act[1], act[0],
                         exp[WIDTH+4], exp[WIDTH+3:4], exp[3], exp[2], exp[1], exp[0]);
            end
        end
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic chk_tok(input string name, input int i, input longint unsigned v,
                           input bit e, input bit b, input bit w);
        longint unsigned a;
        longint unsigned x;
        if (got.size() > i) begin
            a = {got[i].v[31:0], got[i].eol, got[i].blank, got[i].wr};
            x = {v[31:0], e, b, w};
            chk(name, a, x);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s token %0d missing, got %0d tokens", name, i, got.size());
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] b);
        @(negedge clk);
        input_valid = v;
        input_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) drive(1'b1, s[i]);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", num_valid, 0);
        chk("rst_value", num_value, 0);
        chk("rst_flags", {num_eol, num_blank, num_wrapped, overflow}, 0);
        rst = 1'b0;
        num_ready = 1'b1;

        // "12 345\n": each token visible one cycle after its terminator
        got.delete();
        send("12");
        drive(1'b1, 8'h20);
        idle(1);
        chk("sp_term_valid", num_valid, 1);
        chk("sp_term_value", num_value, 12);
        send("345");
        drive(1'b1, 8'h0A);
        idle(1);
        chk("nl_term_valid", num_valid, 1);
        chk("nl_term_value", num_value, 345);
        idle(4);
        chk("t1_count", got.size(), 2);
        chk_tok("t1_tok0", 0, 12, 0, 0, 0);
        chk_tok("t1_tok1", 1, 345, 1, 0, 0);

        // "7\n\n" and "\r\n"
        got.delete();
        send("7");
        drive(1'b1, 8'h0A);
        drive(1'b1, 8'h0A);
        idle(4);
        chk("t2_count", got.size(), 2);
        chk_tok("t2_tok0", 0, 7, 1, 0, 0);
        chk_tok("t2_tok1", 1, 0, 1, 1, 0);
        got.delete();
        drive(1'b1, 8'h0D);
        drive(1'b1, 8'h0A);
        idle(4);
        chk("t3_count", got.size(), 1);
        chk_tok("t3_tok0", 0, 0, 1, 1, 0);

        // Wrap boundary
        got.delete();
        send("4294967296,");
        send("4294967295,");
        idle(4);
        chk("t4_count", got.size(), 2);
        chk_tok("t4_wrap", 0, 0, 0, 0, 1);
        chk_tok("t4_max", 1, 64'd4294967295, 0, 0, 0);

        // Overflow with consumer stalled
        got.delete();
        num_ready = 1'b0;
        send("1,2,3,4,5,");
        idle(2);
        chk("t5_valid", num_valid, 1);
        chk("t5_ovf", overflow, 1);
        num_ready = 1'b1;
        idle(8);
        chk("t5_count", got.size(), 4);
        for (int i = 0; i < 4; i++) chk_tok("t5_tok", i, i + 1, 0, 0, 0);
        chk("t5_ovf_sticky", overflow, 1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("t5_ovf_cleared", overflow, 0);

        // Full FIFO, pop and push in the same cycle
        got.delete();
        num_ready = 1'b0;
        send("1,2,3,4,5");
        idle(1);
        @(negedge clk);
        input_valid = 1'b1;
        input_data  = ",";
        num_ready   = 1'b1;
        @(negedge clk);
        input_valid = 1'b0;
        num_ready   = 1'b0;
        chk("t6_ovf", overflow, 0);
        num_ready = 1'b1;
        idle(8);
        chk("t6_count", got.size(), 5);
        for (int i = 0; i < 5; i++) chk_tok("t6_tok", i, i + 1, 0, 0, 0);
        chk("t6_ovf_end", overflow, 0);

        // Reset mid-number with a token queued
        got.delete();
        num_ready = 1'b0;
        send("3,98");
        @(negedge clk);
        input_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t7_rst_valid", num_valid, 0);
        chk("t7_rst_value", num_value, 0);
        chk("t7_rst_flags", {num_eol, num_blank, num_wrapped, overflow}, 0);
        rst = 1'b0;
        send("5");
        drive(1'b1, 8'h0A);
        num_ready = 1'b1;
        idle(4);
        chk("t7_count", got.size(), 1);
        chk_tok("t7_tok", 0, 5, 1, 0, 0);

        // Randomized traffic, checked every cycle against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int mode;
            int r;
            mode = (cyc / 500) % 3;
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            num_ready = (mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            input_valid = ($urandom_range(0, 5) != 0);
            if (mode == 1) r = ($urandom_range(0, 24) == 0) ? $urandom_range(10, 14) : $urandom_range(0, 9);
            else r = $urandom_range(0, 14);
            case (r)
                10:      input_data = 8'h0A;
                11:      input_data = 8'h0D;
                12:      input_data = 8'h2C;
                13:      input_data = 8'h20;
                14:      input_data = 8'($urandom_range(0, 255));
                default: input_data = 8'h30 + 8'(r);
            endcase
        end
        rst = 1'b0;
        num_ready = 1'b1;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
